light_display_driver: RTL and testbench
=======================================

// Module: light_display_driver
// PURPOSE
//  Downstream consumer of the traffic-light sequencer's phase code and countdown value.
//  - Decodes the 2-bit phase into lamp drives.
//  - Converts the countdown to two BCD digits with an iterative double-dabble FSM.
//  - Time-multiplexes both digits onto one active-low 7-segment bus for the board display.
// PARAMETERS
//  SCAN_DIV   1000  clk cycles each digit is enabled before the scan flips (>=2)
//  BLINK_DIV  500   clk cycles per yellow-lamp half-period (used only with YELLOW_BLINK_EN, >=2)
// PORTS
//  clk        in   1   system clock; all state on posedge
//  reset      in   1   asynchronous, active-high reset
//  phase      in   2   sequencer phase: 00 OFF(yellow), 01 LEFT, 10 FORWARD, 11 RIGHT
//  count      in   32  sequencer countdown value (unsigned)
//  lamp       out  4   {yellow, right, forward, left}, active-high
//  seg        out  8   {dp,g,f,e,d,c,b,a}, active-low
//  an         out  2   digit enables, active-low; an[1]=tens, an[0]=units
//  busy       out  1   high while a BCD conversion is in progress
// BEHAVIOUR
//  Reset values: lamp=4'b0000, seg=8'hFF, an=2'b11, busy=0.
//  Reset also clears: digit regs=0, scan/blink dividers=0, FSM=IDLE, sampled phase/count=0.
//  Reset is honoured in any state, including mid-conversion.
//  Input sampling: phase and count are registered every cycle into ph_q / cnt_q.
//  - A change is flagged when {phase,count} != {ph_q,cnt_q}.
//  Lamp decode (from ph_q; 1 cycle after input):
//  - 01 -> 0001, 10 -> 0010, 11 -> 0100, 00 -> 1000.
//  Saturation: the conversion operand is min(cnt_q, 99) as a 7-bit value; any count > 99 displays 99.
//  Conversion FSM: IDLE -> LOAD -> SHIFT x7 -> DONE -> IDLE.
//  - IDLE: on a change flag go to LOAD.
//  - LOAD: latch the saturated operand, clear the 8-bit BCD scratch, set busy=1.
//  - SHIFT: each cycle, add 3 to any BCD nibble >= 5, then shift {bcd, operand} left by 1.
//    A 3-bit iteration counter runs 0..6.
//  - DONE: copy the scratch into tens/units display regs, busy=0.
//  - Latency: display regs update 10 cycles after the input edge that changed {phase,count}.
//  - Restart rule: a change flag while busy (LOAD/SHIFT) aborts the conversion and re-enters LOAD
//    with the newest operand. Display regs keep their old value until a conversion reaches DONE.
//  - A change flag in the DONE cycle: DONE completes, then the next cycle goes to LOAD.
//  Scan:
//  - A divider counts 0..SCAN_DIV-1 and wraps.
//  - On wrap, the digit select toggles; an and seg switch in the same cycle (no ghosting cycle).
//  - Select 0 drives an=10 with the units digit; select 1 drives an=01 with the tens digit.
//  - Leading-zero blanking: when tens==0, the tens slot drives seg=8'hFF (an still asserted).
//  - dp is always 1 (off).
//  - Segment map (active-low gfedcba): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//    5=0010010 6=0000010 7=1111000 8=0000000 9=0010000.
//  Scan, lamps and conversion run independently; no input stalls the scan.
// CONFIGURATION
//  YELLOW_BLINK_EN defined:
//  - While ph_q==00, lamp[3] toggles every BLINK_DIV cycles, starting lit on entry to 00.
//  - The blink divider is cleared whenever ph_q!=00.
//  YELLOW_BLINK_EN undefined:
//  - lamp[3] is steady 1 while ph_q==00.
//  - The blink divider and its logic are not synthesised.
// TESTING (sim with SCAN_DIV=4, BLINK_DIV=3)
//  1. Reset pulse mid-run -> lamp=0000, seg=FF, an=11, busy=0 asynchronously.
//     After release with phase=10, count=15: lamp=0010 next cycle.
//     Tens slot shows 1 (seg=F9) and units slot shows 5 (seg=92) from cycle 10.
//  2. count=7 -> tens slot blanked (seg=FF with an=01); units slot shows seg=F8.
//     count=100 and count=32'hFFFF_FFFF -> display shows 99.
//  3. count steps 10 -> 9 at cycle 5 of a conversion -> conversion restarts.
//     Display goes straight from the old value to 09 with no intermediate value; busy stays high until then.
//  4. Hold inputs constant for 20 cycles -> an toggles 10/01 exactly every 4 cycles.
//     seg always matches the enabled digit in the same cycle.
//  5. phase=00 with YELLOW_BLINK_EN -> lamp[3] pattern 1,1,1,0,0,0,1 from ph_q entry.
//     Without the macro, lamp[3] is steady 1.
//     phase 00->01 -> lamp=0001 one cycle later.

Source files
------------

// File: rtl/light_display_driver.sv
// Lamp decode, iterative double-dabble BCD conversion and two-digit 7-segment scan.
// Optional build macro YELLOW_BLINK_EN makes the yellow lamp blink while the phase is OFF.
module light_display_driver #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  phase,
    input  logic [31:0] count,
    output logic [3:0]  lamp,
    output logic [7:0]  seg,
    output logic [1:0]  an,
    output logic        busy
);

    // state | meaning
    // IDLE  | display stable, waiting for {phase,count} to change
    // LOAD  | latch saturated operand, clear BCD scratch
    // SHIFT | seven add-3/shift iterations
    // DONE  | publish scratch to the tens/units display regs
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    if (SCAN_DIV < 2 || BLINK_DIV < 2) begin : g_bad_param
        $error("SCAN_DIV and BLINK_DIV must both be >= 2");
    end

    state_t      state, state_nx;
    logic [1:0]  ph_q;
    logic [31:0] cnt_q;
    logic        change;
    logic [6:0]  operand;
    logic [6:0]  bin_sr;
    logic [7:0]  bcd_sr, bcd_adj;
    logic [2:0]  iter;
    logic [3:0]  tens, units;
    logic [SW-1:0] scan_cnt;
    logic        scan_sel;
    logic        out_en;
    logic        yellow;

    assign change  = {phase, count} != {ph_q, cnt_q};
    assign operand = (cnt_q > 32'd99) ? 7'd99 : cnt_q[6:0];
    assign bcd_adj = {(bcd_sr[7:4] >= 4'd5) ? bcd_sr[7:4] + 4'd3 : bcd_sr[7:4],
                      (bcd_sr[3:0] >= 4'd5) ? bcd_sr[3:0] + 4'd3 : bcd_sr[3:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_q   <= 2'b00;
            cnt_q  <= 32'd0;
            out_en <= 1'b0;
            state  <= IDLE;
        end else begin
            ph_q   <= phase;
            cnt_q  <= count;
            out_en <= 1'b1;
            state  <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (change) state_nx = LOAD;
            LOAD:    state_nx = change ? LOAD : SHIFT;
            SHIFT: begin
                if (change)             state_nx = LOAD;
                else if (iter == 3'd6)  state_nx = DONE;
            end
            DONE:    state_nx = change ? LOAD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_sr <= 7'd0;
            bcd_sr <= 8'd0;
            iter   <= 3'd0;
            tens   <= 4'd0;
            units  <= 4'd0;
            busy   <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    bin_sr <= operand;
                    bcd_sr <= 8'd0;
                    iter   <= 3'd0;
                    busy   <= 1'b1;
                end
                SHIFT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    iter             <= iter + 3'd1;
                end
                DONE: begin
                    tens  <= bcd_sr[7:4];
                    units <= bcd_sr[3:0];
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            scan_sel <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_sel <= ~scan_sel;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

`ifdef YELLOW_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    logic [BW-1:0] blink_cnt;
    logic          blink_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (ph_q != 2'b00) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign yellow = blink_on;
`else
    assign yellow = 1'b1;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // out_en keeps lamps and display dark until the first clock after reset
    always_comb begin
        an  = 2'b11;
        seg = 8'hFF;
        if (out_en) begin
            if (scan_sel) begin
                an  = 2'b01;
                seg = (tens == 4'd0) ? 8'hFF : {1'b1, seg7(tens)};
            end else begin
                an  = 2'b10;
                seg = {1'b1, seg7(units)};
            end
        end
    end

    always_comb begin
        lamp = 4'b0000;
        if (out_en) begin
            case (ph_q)
                2'b01:   lamp = 4'b0001;
                2'b10:   lamp = 4'b0010;
                2'b11:   lamp = 4'b0100;
                default: lamp = {yellow, 3'b000};
            endcase
        end
    end

endmodule

// File: tb/tb_light_display_driver.sv
// Randomized and directed bench for light_display_driver, checked every cycle against
// a timeline model of the conversion, scan period and yellow blink.
module tb_light_display_driver;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  phase;
    logic [31:0] count;
    logic [3:0]  lamp;
    logic [7:0]  seg;
    logic [1:0]  an;
    logic        busy;

    always #5 clk = ~clk;

    light_display_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .phase (phase),
        .count (count),
        .lamp  (lamp),
        .seg   (seg),
        .an    (an),
        .busy  (busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // model: conversion tracked as "edges since start", display digits as integers
    bit          m_live;
    logic [1:0]  m_ph;
    logic [31:0] m_cnt;
    bit          m_inflight;
    int          m_age;
    int          m_val;
    int          m_disp;
    bit          m_busy;
    int          m_edges;
    int          m_yk;

    task automatic model_reset();
        m_live = 0; m_ph = 2'b00; m_cnt = 32'd0;
        m_inflight = 0; m_age = 0; m_val = 0; m_disp = 0;
        m_busy = 0; m_edges = 0; m_yk = 0;
    endtask

    task automatic model_edge();
        bit flag;
        int age_now;
        flag = (phase != m_ph) || (count != m_cnt);
        if (m_inflight) begin
            age_now = m_age + 1;
            if (age_now == 1) m_busy = 1;
            if (age_now == 9) begin
                m_disp = m_val;
                m_busy = 0;
                m_inflight = 0;
            end
            m_age = age_now;
        end
        if (flag) begin
            m_inflight = 1;
            m_age = 0;
            m_val = (count > 32'd99) ? 99 : int'(count);
        end
        if (phase == 2'b00) m_yk = (m_ph == 2'b00) ? m_yk + 1 : 0;
        m_ph = phase;
        m_cnt = count;
        m_edges++;
        m_live = 1;
    endtask

    task automatic check_outputs();
        logic [3:0] e_lamp;
        logic [1:0] e_an;
        logic [7:0] e_seg;
        bit         yel;
        int         tens_d, units_d;
`ifdef YELLOW_BLINK_EN
        yel = ((m_yk / BLINK_DIV) % 2) == 0;
`else
        yel = 1;
`endif
        tens_d  = m_disp / 10;
        units_d = m_disp % 10;
        e_lamp = 4'b0000; e_an = 2'b11; e_seg = 8'hFF;
        if (m_live) begin
            case (m_ph)
                2'b01:   e_lamp = 4'b0001;
                2'b10:   e_lamp = 4'b0010;
                2'b11:   e_lamp = 4'b0100;
                default: e_lamp = {yel, 3'b000};
            endcase
            if (((m_edges / SCAN_DIV) % 2) == 1) begin
                e_an  = 2'b01;
                e_seg = (tens_d == 0) ? 8'hFF : {1'b1, seg_tab[tens_d]};
            end else begin
                e_an  = 2'b10;
                e_seg = {1'b1, seg_tab[units_d]};
            end
        end
        check("lamp", 32'(lamp), 32'(e_lamp));
        check("an",   32'(an),   32'(e_an));
        check("seg",  32'(seg),  32'(e_seg));
        check("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_lamp"}, 32'(lamp), 32'h0);
        check({tag, "_seg"},  32'(seg),  32'hFF);
        check({tag, "_an"},   32'(an),   32'h3);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    // asynchronous reset: assert between edges, check before any clock, hold across one edge
    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_vals("rst_async");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst_held");
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        phase = 2'b00;
        count = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals("rst_init");
        reset = 1'b0;

        step(10);                                   // yellow phase after reset
        phase = 2'b10; count = 32'd15;  step(16);   // display 15
        pulse_reset();                              // mid-run reset
        phase = 2'b10; count = 32'd15;  step(16);
        count = 32'd7;                  step(16);   // tens blanked
        count = 32'd100;                step(16);   // saturates to 99
        count = 32'd0;                  step(12);
        count = 32'hFFFF_FFFF;          step(16);
        count = 32'd10;                 step(14);
        count = 32'd10; phase = 2'b11;  step(5);    // start a conversion, then
        count = 32'd9;                  step(16);   // restart mid-conversion
        count = 32'd42; step(9);                    // change lands in DONE cycle
        count = 32'd43; step(14);
        phase = 2'b00;                  step(20);   // hold constant, blink/scan
        phase = 2'b01;                  step(3);

        for (int seg_i = 0; seg_i < 160; seg_i++) begin
            if (seg_i == 80) pulse_reset();
            case ($urandom_range(0, 5))
                0:       count = $urandom;
                5:       ;
                default: count = 32'($urandom_range(0, 120));
            endcase
            if ($urandom_range(0, 2) == 0) phase = 2'($urandom_range(0, 3));
            step($urandom_range(1, 13));
        end
        step(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
